// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, 32x32 signed -> 64-bit HI/LO.
// One add/sub and one arithmetic shift per clock through the add_new ripple adder.

module add_new (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        c_out
);

    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule

module booth_mul_seq #(
    parameter int WIDTH      = 32,
    parameter int DONE_PULSE = 1
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;

    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   neg_m;
    logic [4:0]       cnt;

    logic [WIDTH-1:0] neg_lo;
    logic             neg_c;
    logic [WIDTH:0]   neg_full;

    logic [1:0]       booth;
    logic             add_en;
    logic [WIDTH:0]   y;
    logic [WIDTH-1:0] s_lo;
    logic             s_c;
    logic [WIDTH:0]   s_full;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;
    logic             q1_next;

    // Two's complement of the incoming multiplicand, widened to 33 bits
    // so that -(-2^31) is representable as +2^31.
    add_new u_neg (
        .a     (~mcand),
        .b     (32'd1),
        .cin   (1'b0),
        .sum   (neg_lo),
        .c_out (neg_c)
    );

    assign neg_full = {~mcand[WIDTH-1] ^ neg_c, neg_lo};

    assign booth  = {q[0], q_1};
    assign add_en = (booth == 2'b01) || (booth == 2'b10);
    assign y      = (booth == 2'b10) ? neg_m : {m[WIDTH-1], m};

    add_new u_step (
        .a     (a[WIDTH-1:0]),
        .b     (y[WIDTH-1:0]),
        .cin   (1'b0),
        .sum   (s_lo),
        .c_out (s_c)
    );

    assign s_full  = add_en ? {a[WIDTH] ^ y[WIDTH] ^ s_c, s_lo} : a;
    assign a_next  = {s_full[WIDTH], s_full[WIDTH:1]};
    assign q_next  = {s_full[0], q[WIDTH-1:1]};
    assign q1_next = q[0];

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            a     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            m     <= '0;
            neg_m <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m     <= mcand;
                        q     <= mplier;
                        a     <= '0;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                        neg_m <= neg_full;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a   <= a_next;
                    q   <= q_next;
                    q_1 <= q1_next;
                    cnt <= cnt + 5'd1;
                    // Product is published on the same edge as the last step.
                    if (cnt == 5'd31) begin
                        hi    <= a_next[WIDTH-1:0];
                        lo    <= q_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (DONE_PULSE != 0) begin
                        done <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
